rx_os_checker: RTL and testbench

- Per-lane receive ordered-set qualifier. It sits directly upstream of the master RX LTSSM.
- For each lane it counts consecutive received TS1/TS2/IDL ordered sets that satisfy the acceptance rule of the current LTSSM substate.
- It raises that lane's bit of countersComparators once the count reaches the target that the LTSSM supplies.
- Inputs are ordered sets already decoded by the per-lane OS decoder.

---
 rtl/rx_os_checker.sv | 124 ++++++++++++
 tb/tb_rx_os_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_os_checker.sv
// Per-lane receive ordered-set qualifier: counts consecutive TS1/TS2/IDL sets
// accepted by the current LTSSM substate and flags lanes that reach the target.
module rx_os_checker #(
  parameter int unsigned MAXLANES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              substate,
  input  logic [4:0]              comparatorsCount,
  input  logic [MAXLANES-1:0]     resetOsCheckers,
  input  logic [MAXLANES-1:0]     osValid,
  input  logic [2*MAXLANES-1:0]   osType,
  input  logic [MAXLANES-1:0]     linkPad,
  input  logic [MAXLANES-1:0]     lanePad,
  input  logic [8*MAXLANES-1:0]   linkNum,
  input  logic [8*MAXLANES-1:0]   laneNum,
  output logic [MAXLANES-1:0]     countersComparators,
  output logic [5*MAXLANES-1:0]   matchCount
);

  typedef enum logic [3:0] {
    DETECT_QUIET          = 4'd0,
    DETECT_ACTIVE         = 4'd1,
    POLLING_ACTIVE        = 4'd2,
    POLLING_CONFIGURATION = 4'd3,
    CONFIG_LW_START       = 4'd4,
    CONFIG_LW_ACCEPT      = 4'd5,
    CONFIG_LN_WAIT        = 4'd6,
    CONFIG_LN_ACCEPT      = 4'd7,
    CONFIG_COMPLETE       = 4'd8,
    CONFIG_IDLE           = 4'd9
  } substate_t;

  typedef enum logic [1:0] {
    OS_TS1   = 2'b00,
    OS_TS2   = 2'b01,
    OS_OTHER = 2'b10,
    OS_IDL   = 2'b11
  } os_type_t;

  logic [3:0]                  snap_q;
  logic [MAXLANES-1:0][4:0]    count_q, count_d;
  logic [MAXLANES-1:0]         prev_valid_q, prev_valid_d;
  logic [MAXLANES-1:0][19:0]   prev_fields_q, prev_fields_d;
  logic [MAXLANES-1:0]         cmp_q, cmp_d;
  logic                        substate_change;
  logic                        consec_rule;
  logic                        skp_transparent;

  function automatic logic accepts(input logic [3:0] s, input logic [1:0] t,
                                   input logic lkp, input logic lnp);
    logic r;
    r = 1'b0;
    case (substate_t'(s))
      POLLING_ACTIVE:        r = (t == OS_TS1) || (t == OS_TS2);
      POLLING_CONFIGURATION: r = (t == OS_TS2);
      CONFIG_LW_START:       r = (t == OS_TS1) && !lkp;
      CONFIG_LW_ACCEPT:      r = (t == OS_TS1) && !lkp && !lnp;
      CONFIG_LN_WAIT:        r = (t == OS_TS2) && !lkp;
      CONFIG_LN_ACCEPT,
      CONFIG_COMPLETE:       r = (t == OS_TS2) && !lkp && !lnp;
      CONFIG_IDLE:           r = (t == OS_IDL);
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

  always_comb begin
    substate_change = (substate != snap_q);
    consec_rule     = (substate >= 4'd4) && (substate <= 4'd8);
    skp_transparent = (substate >= 4'd2) && (substate <= 4'd9);
    count_d         = count_q;
    prev_valid_d    = prev_valid_q;
    prev_fields_d   = prev_fields_q;
    cmp_d           = '0;
    for (int unsigned i = 0; i < MAXLANES; i++) begin
      logic [19:0] fields;
      fields = {osType[2*i +: 2], linkPad[i], lanePad[i],
                linkNum[8*i +: 8], laneNum[8*i +: 8]};
      if (!resetOsCheckers[i] || substate_change) begin
        count_d[i]      = '0;
        prev_valid_d[i] = 1'b0;
      end else if (osValid[i]) begin
        if (accepts(substate, osType[2*i +: 2], linkPad[i], lanePad[i])) begin
          // A differing set restarts the run at 1 rather than 0: it is itself a match.
          if (consec_rule && prev_valid_q[i] && (fields != prev_fields_q[i]))
            count_d[i] = 5'd1;
          else if (count_q[i] != 5'd31)
            count_d[i] = count_q[i] + 5'd1;
          prev_fields_d[i] = fields;
          prev_valid_d[i]  = 1'b1;
        end else if (!(osType[2*i +: 2] == OS_OTHER && skp_transparent)) begin
          count_d[i]      = '0;
          prev_valid_d[i] = 1'b0;
        end
      end
      cmp_d[i] = (count_d[i] >= comparatorsCount) && (comparatorsCount != 5'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q        <= 4'hF;
      count_q       <= '0;
      prev_valid_q  <= '0;
      prev_fields_q <= '0;
      cmp_q         <= '0;
    end else begin
      snap_q        <= substate;
      count_q       <= count_d;
      prev_valid_q  <= prev_valid_d;
      prev_fields_q <= prev_fields_d;
      cmp_q         <= cmp_d;
    end
  end

  always_comb begin
    countersComparators = cmp_q;
    matchCount          = '0;
    for (int unsigned i = 0; i < MAXLANES; i++)
      matchCount[5*i +: 5] = count_q[i];
  end

endmodule

// File: tb/tb_rx_os_checker.sv
// Self-checking bench for rx_os_checker: directed vector table, corner-case
// sequences, then randomized traffic against a behavioural lane model.
module tb_rx_os_checker;
  localparam int unsigned L = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       substate;
  logic [4:0]       comparatorsCount;
  logic [L-1:0]     resetOsCheckers, osValid, linkPad, lanePad;
  logic [2*L-1:0]   osType;
  logic [8*L-1:0]   linkNum, laneNum;
  logic [L-1:0]     countersComparators;
  logic [5*L-1:0]   matchCount;

  always #5 clk = ~clk;

  rx_os_checker #(.MAXLANES(L)) dut (
    .clk(clk), .reset(reset), .substate(substate),
    .comparatorsCount(comparatorsCount), .resetOsCheckers(resetOsCheckers),
    .osValid(osValid), .osType(osType), .linkPad(linkPad), .lanePad(lanePad),
    .linkNum(linkNum), .laneNum(laneNum),
    .countersComparators(countersComparators), .matchCount(matchCount)
  );

  int total = 0;
  int bad   = 0;

  int          m_cnt[L];
  bit          m_pv[L];
  logic [19:0] m_pf[L];
  bit          m_cmp[L];
  int          m_snap;

  function automatic bit accepts(int s, logic [1:0] t, logic lkp, logic lnp);
    case (s)
      2:       return t == 2'b00 || t == 2'b01;
      3:       return t == 2'b01;
      4:       return t == 2'b00 && !lkp;
      5:       return t == 2'b00 && !lkp && !lnp;
      6:       return t == 2'b01 && !lkp;
      7, 8:    return t == 2'b01 && !lkp && !lnp;
      9:       return t == 2'b11;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    bit chg;
    if (reset) begin
      m_snap = 15;
      for (int i = 0; i < L; i++) begin
        m_cnt[i] = 0; m_pv[i] = 0; m_pf[i] = '0; m_cmp[i] = 0;
      end
    end else begin
      chg    = (int'(substate) != m_snap);
      m_snap = int'(substate);
      for (int i = 0; i < L; i++) begin
        logic [1:0]  t;
        logic [19:0] f;
        t = osType[2*i +: 2];
        f = {t, linkPad[i], lanePad[i], linkNum[8*i +: 8], laneNum[8*i +: 8]};
        if (!resetOsCheckers[i] || chg) begin
          m_cnt[i] = 0; m_pv[i] = 0;
        end else if (osValid[i]) begin
          if (accepts(m_snap, t, linkPad[i], lanePad[i])) begin
            if (m_snap >= 4 && m_snap <= 8 && m_pv[i] && f != m_pf[i]) m_cnt[i] = 1;
            else m_cnt[i] = (m_cnt[i] + 1 > 31) ? 31 : m_cnt[i] + 1;
            m_pf[i] = f; m_pv[i] = 1;
          end else if (!(t == 2'b10 && m_snap >= 2 && m_snap <= 9)) begin
            m_cnt[i] = 0; m_pv[i] = 0;
          end
        end
        m_cmp[i] = (comparatorsCount != 0) && (m_cnt[i] >= int'(comparatorsCount));
      end
    end
  endtask

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [5*L-1:0] emc;
    logic [L-1:0]   ecc;
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < L; i++) begin
      emc[5*i +: 5] = m_cnt[i][4:0];
      ecc[i]        = m_cmp[i];
    end
    check("model_matchCount", matchCount, emc);
    check("model_comparators", countersComparators, ecc);
  endtask

  task automatic clear_os();
    osValid = '0; osType = '0; linkPad = '0; lanePad = '0;
    linkNum = '0; laneNum = '0;
  endtask

  task automatic set_os(int i, logic [1:0] t, logic lkp, logic lnp,
                        logic [7:0] lk, logic [7:0] ln);
    osValid[i] = 1'b1; osType[2*i +: 2] = t; linkPad[i] = lkp; lanePad[i] = lnp;
    linkNum[8*i +: 8] = lk; laneNum[8*i +: 8] = ln;
  endtask

  typedef struct {
    int sub; int tgt; int lane; bit vld; logic [1:0] t;
    bit lkp; bit lnp; logic [7:0] lk; logic [7:0] ln;
    int ecnt; bit ecmp;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int sub, int tgt, int lane, bit vld, logic [1:0] t,
                              logic [7:0] lk, logic [7:0] ln, int ecnt, bit ecmp);
    vec_t v;
    v = '{sub, tgt, lane, vld, t, 1'b0, 1'b0, lk, ln, ecnt, ecmp};
    return v;
  endfunction

  initial begin
    reset = 1'b1; substate = 4'd0; comparatorsCount = 5'd0;
    resetOsCheckers = '1; clear_os();
    step();
    check("reset_count", matchCount, '0);
    check("reset_cmp", countersComparators, '0);
    reset = 1'b0;

    // lane 0: eight TS2 in pollingConfiguration, target 8
    tbl.push_back(mk(3, 8, 0, 0, 2'b01, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(3, 8, 0, 1, 2'b01, 0, 0, k, k == 8));
    // lane 1: 5 TS1, IDL breaks the run, then 8 TS1
    tbl.push_back(mk(2, 8, 1, 0, 2'b00, 0, 0, 0, 0));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(2, 8, 1, 1, 2'b00, 0, 0, k, 0));
    tbl.push_back(mk(2, 8, 1, 1, 2'b11, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(2, 8, 1, 1, 2'b00, 0, 0, k, k == 8));
    // lane 2: lane number change restarts the run
    tbl.push_back(mk(7, 2, 2, 0, 2'b01, 0, 0, 0, 0));
    tbl.push_back(mk(7, 2, 2, 1, 2'b01, 5, 2, 1, 0));
    tbl.push_back(mk(7, 2, 2, 1, 2'b01, 5, 3, 1, 0));
    tbl.push_back(mk(7, 2, 2, 1, 2'b01, 5, 3, 2, 1));

    for (int k = 0; k < tbl.size(); k++) begin
      clear_os();
      substate = tbl[k].sub[3:0];
      comparatorsCount = tbl[k].tgt[4:0];
      if (tbl[k].vld)
        set_os(tbl[k].lane, tbl[k].t, tbl[k].lkp, tbl[k].lnp, tbl[k].lk, tbl[k].ln);
      step();
      check("tbl_count", matchCount[5*tbl[k].lane +: 5], tbl[k].ecnt);
      check("tbl_cmp", countersComparators[tbl[k].lane], tbl[k].ecmp);
    end

    // substate change coinciding with a strobe
    clear_os(); substate = 4'd2; comparatorsCount = 5'd8; step();
    for (int k = 0; k < 6; k++) begin
      clear_os(); set_os(0, 2'b00, 0, 0, 0, 0); step();
    end
    check("pre_change_count", matchCount[4:0], 5'd6);
    clear_os(); substate = 4'd3; set_os(0, 2'b01, 0, 0, 0, 0); step();
    check("substate_change_count", matchCount, '0);
    check("substate_change_cmp", countersComparators, '0);

    // lane disable then saturation
    for (int k = 0; k < 8; k++) begin
      clear_os(); set_os(3, 2'b01, 0, 0, 0, 0); step();
    end
    check("lane3_count8", matchCount[15 +: 5], 5'd8);
    check("lane3_cmp_on", countersComparators[3], 1'b1);
    clear_os(); resetOsCheckers[3] = 1'b0; set_os(3, 2'b01, 0, 0, 0, 0); step();
    check("lane3_disabled_count", matchCount[15 +: 5], 5'd0);
    check("lane3_disabled_cmp", countersComparators[3], 1'b0);
    resetOsCheckers[3] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      clear_os(); set_os(3, 2'b01, 0, 0, 0, 0); step();
    end
    check("lane3_saturate", matchCount[15 +: 5], 5'd31);
    check("lane3_sat_cmp", countersComparators[3], 1'b1);

    // reset mid-count with target 0
    clear_os(); substate = 4'd2; comparatorsCount = 5'd0; step();
    for (int k = 0; k < 4; k++) begin
      clear_os(); for (int i = 0; i < L; i++) set_os(i, 2'b00, 0, 0, 0, 0); step();
    end
    check("all_lanes_4", matchCount, {L{5'd4}});
    check("target0_cmp", countersComparators, '0);
    reset = 1'b1; step();
    check("midreset_count", matchCount, '0);
    check("midreset_cmp", countersComparators, '0);
    reset = 1'b0; clear_os(); step();
    for (int k = 0; k < 3; k++) begin
      clear_os(); for (int i = 0; i < L; i++) set_os(i, 2'b00, 0, 0, 0, 0); step();
    end
    check("post_reset_3", matchCount, {L{5'd3}});
    check("post_reset_cmp", countersComparators, '0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) substate = 4'($urandom_range(0, 10));
      if (n % 100 == 0 || $urandom_range(0, 49) == 0)
        comparatorsCount = 5'($urandom_range(0, 12));
      reset = ($urandom_range(0, 299) == 0);
      clear_os();
      for (int i = 0; i < L; i++) begin
        resetOsCheckers[i] = ($urandom_range(0, 31) != 0);
        if ($urandom_range(0, 3) != 0)
          set_os(i, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 8'($urandom_range(0, 7) == 0), 8'($urandom_range(0, 7) == 0));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
